// File: rtl/uart_rx_bram_writer.sv
// 8E1 UART receiver that writes each good byte sequentially into BRAM port A.
// Ports: w_clk/w_resetn (sync, active-low), uart_rxd line, write_enable arm
// level, BRAM port A (bram_we/bram_addr/bram_din), byte_count, write_done,
// sticky parity_err/frame_err, and an 8-bit led state indicator.

module uart_rx_bram_writer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int WRITE_DEPTH  = 2048,
  parameter int ADDR_W       = 11
) (
  input  logic              w_clk,
  input  logic              w_resetn,
  input  logic              uart_rxd,
  input  logic              write_enable,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic [ADDR_W:0]   byte_count,
  output logic              write_done,
  output logic              parity_err,
  output logic              frame_err,
  output logic [7:0]        led
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_END =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W + 1)'(WRITE_DEPTH);

  localparam logic [7:0] LED_IDLE  = 8'b1100_0000;
  localparam logic [7:0] LED_WAIT  = 8'b0011_0000;
  localparam logic [7:0] LED_WRITE = 8'b0000_1100;
  localparam logic [7:0] LED_DONE  = 8'b0000_0011;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_st_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE,
    DONE
  } wr_st_t;

  // synchroniser plus one history stage for falling-edge detection
  logic rx_s1;
  logic rx_s2;
  logic rx_d;

  rx_st_t           rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_par;
  logic             rx_valid;
  logic             rx_perr_p;
  logic             rx_ferr_p;
  logic             rx_bad_par;
  logic             rx_fall;

  wr_st_t           wr_st;
  logic [ADDR_W:0]  cnt_nxt;

  assign rx_bad_par = ^{rx_shift, rx_par};
  assign rx_fall    = rx_d & ~rx_s2;
  assign cnt_nxt    = byte_count + 1'b1;

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      rx_st     <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_perr_p <= 1'b0;
      rx_ferr_p <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_perr_p <= 1'b0;
      rx_ferr_p <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) begin
            rx_st <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            // a line that is high again at mid-start was a glitch
            rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_st <= RX_PARITY;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_par <= rx_s2;
            rx_st  <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt    <= '0;
            rx_st     <= RX_IDLE;
            rx_valid  <= ~rx_bad_par & rx_s2;
            rx_perr_p <= rx_bad_par;
            rx_ferr_p <= ~rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_st <= RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      wr_st      <= IDLE;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      byte_count <= '0;
      write_done <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      led        <= '0;
    end else begin
      if (rx_perr_p) begin
        parity_err <= 1'b1;
      end
      if (rx_ferr_p) begin
        frame_err <= 1'b1;
      end
      case (wr_st)
        IDLE: begin
          bram_we    <= 1'b0;
          write_done <= 1'b0;
          led        <= LED_IDLE;
          if (write_enable) begin
            byte_count <= '0;
            bram_addr  <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            led        <= LED_WAIT;
            wr_st      <= WAIT;
          end
        end
        WAIT: begin
          if (!write_enable) begin
            led   <= LED_IDLE;
            wr_st <= IDLE;
          end else if (rx_valid) begin
            bram_din <= rx_shift;
            bram_we  <= 1'b1;
            led      <= LED_WRITE;
            wr_st    <= WRITE;
          end
        end
        WRITE: begin
          // strobe always completes, even if the arm drops this cycle
          bram_we    <= 1'b0;
          bram_addr  <= bram_addr + 1'b1;
          byte_count <= cnt_nxt;
          if (!write_enable) begin
            led   <= LED_IDLE;
            wr_st <= IDLE;
          end else if (cnt_nxt == DEPTH_C) begin
            write_done <= 1'b1;
            led        <= LED_DONE;
            wr_st      <= DONE;
          end else begin
            led   <= LED_WAIT;
            wr_st <= WAIT;
          end
        end
        DONE: begin
          bram_we <= 1'b0;
          if (!write_enable) begin
            write_done <= 1'b0;
            led        <= LED_IDLE;
            wr_st      <= IDLE;
          end
        end
        default: begin
          wr_st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_bram_writer.sv
// Bench for uart_rx_bram_writer: small-depth instance for directed cases,
// full-depth instance (fast baud) for the 2048-byte fill and wrap.

module tb_uart_rx_bram_writer;

  localparam int CPB_A = 16;
  localparam int DEP_A = 4;
  localparam int AW_A  = 2;
  localparam int CPB_B = 3;
  localparam int DEP_B = 2048;
  localparam int AW_B  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic a_rxd, a_en, b_rxd, b_en;

  logic            a_we, a_done, a_pe, a_fe;
  logic [AW_A-1:0] a_addr;
  logic [7:0]      a_din, a_led;
  logic [AW_A:0]   a_cnt;

  logic            b_we, b_done, b_pe, b_fe;
  logic [AW_B-1:0] b_addr;
  logic [7:0]      b_din, b_led;
  logic [AW_B:0]   b_cnt;

  uart_rx_bram_writer #(
    .CLKS_PER_BIT(CPB_A),
    .WRITE_DEPTH (DEP_A),
    .ADDR_W      (AW_A)
  ) dut_a (
    .w_clk       (clk),
    .w_resetn    (rstn),
    .uart_rxd    (a_rxd),
    .write_enable(a_en),
    .bram_we     (a_we),
    .bram_addr   (a_addr),
    .bram_din    (a_din),
    .byte_count  (a_cnt),
    .write_done  (a_done),
    .parity_err  (a_pe),
    .frame_err   (a_fe),
    .led         (a_led)
  );

  uart_rx_bram_writer #(
    .CLKS_PER_BIT(CPB_B),
    .WRITE_DEPTH (DEP_B),
    .ADDR_W      (AW_B)
  ) dut_b (
    .w_clk       (clk),
    .w_resetn    (rstn),
    .uart_rxd    (b_rxd),
    .write_enable(b_en),
    .bram_we     (b_we),
    .bram_addr   (b_addr),
    .bram_din    (b_din),
    .byte_count  (b_cnt),
    .write_done  (b_done),
    .parity_err  (b_pe),
    .frame_err   (b_fe),
    .led         (b_led)
  );

  int checks = 0;
  int fails  = 0;

  // model: 0 idle, 1 waiting for bytes, 2 done
  int          m_st[2];
  int          m_cnt[2];
  int          m_addr[2];
  bit          m_pe[2];
  bit          m_fe[2];
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  int          log_a[$];
  logic [7:0]  log_d[$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int ch, logic v);
    if (ch == 0) a_rxd = v;
    else b_rxd = v;
  endtask

  task automatic send(int ch, logic [7:0] d, logic p, logic s);
    int cpb;
    int gap;
    cpb = (ch == 0) ? CPB_A : CPB_B;
    gap = (ch == 0) ? 2 * CPB_A : 0;
    drive(ch, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(ch, d[i]);
      tick(cpb);
    end
    drive(ch, p);
    tick(cpb);
    drive(ch, s);
    tick(cpb);
    drive(ch, 1'b1);
    if (gap > 0) tick(gap);
  endtask

  function automatic void model_frame(int ch, logic [7:0] d,
                                      logic p, logic s);
    bit bp;
    bit bs;
    int dep;
    int amod;
    logic [18:0] e;
    bp   = ^{d, p};
    bs   = !s;
    dep  = (ch == 0) ? DEP_A : DEP_B;
    amod = (ch == 0) ? (1 << AW_A) : (1 << AW_B);
    if (bp) m_pe[ch] = 1'b1;
    if (bs) m_fe[ch] = 1'b1;
    if (!bp && !bs && m_st[ch] == 1) begin
      e = {11'(m_addr[ch]), d};
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
      m_addr[ch] = (m_addr[ch] + 1) % amod;
      m_cnt[ch]++;
      if (m_cnt[ch] == dep) m_st[ch] = 2;
    end
  endfunction

  task automatic frame(int ch, logic [7:0] d, logic p, logic s);
    model_frame(ch, d, p, s);
    send(ch, d, p, s);
  endtask

  task automatic good(int ch, logic [7:0] d);
    frame(ch, d, ^d, 1'b1);
  endtask

  task automatic arm(int ch);
    if (ch == 0) a_en = 1'b1;
    else b_en = 1'b1;
    tick(2);
    m_st[ch]   = 1;
    m_cnt[ch]  = 0;
    m_addr[ch] = 0;
    m_pe[ch]   = 1'b0;
    m_fe[ch]   = 1'b0;
  endtask

  task automatic disarm(int ch);
    if (ch == 0) a_en = 1'b0;
    else b_en = 1'b0;
    tick(2);
    m_st[ch] = 0;
  endtask

  function automatic logic [7:0] led_of(int st);
    logic [7:0] r;
    r = 8'b1100_0000;
    if (st == 1) r = 8'b0011_0000;
    if (st == 2) r = 8'b0000_0011;
    return r;
  endfunction

  task automatic check_state(int ch, string nm);
    if (ch == 0) begin
      chk({nm, " count"}, 32'(a_cnt), m_cnt[ch]);
      chk({nm, " addr"}, 32'(a_addr), m_addr[ch]);
      chk({nm, " done"}, 32'(a_done), 32'(m_st[ch] == 2));
      chk({nm, " led"}, 32'(a_led), 32'(led_of(m_st[ch])));
      chk({nm, " perr"}, 32'(a_pe), 32'(m_pe[ch]));
      chk({nm, " ferr"}, 32'(a_fe), 32'(m_fe[ch]));
      chk({nm, " we"}, 32'(a_we), 0);
      chk({nm, " pending"}, 32'(q0.size()), 0);
    end else begin
      chk({nm, " count"}, 32'(b_cnt), m_cnt[ch]);
      chk({nm, " addr"}, 32'(b_addr), m_addr[ch]);
      chk({nm, " done"}, 32'(b_done), 32'(m_st[ch] == 2));
      chk({nm, " led"}, 32'(b_led), 32'(led_of(m_st[ch])));
      chk({nm, " perr"}, 32'(b_pe), 32'(m_pe[ch]));
      chk({nm, " ferr"}, 32'(b_fe), 32'(m_fe[ch]));
      chk({nm, " we"}, 32'(b_we), 0);
      chk({nm, " pending"}, 32'(q1.size()), 0);
    end
  endtask

  task automatic compare_loop();
    logic pa;
    logic pb;
    logic [18:0] e;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (a_we) begin
          chk("a_we_single", 32'(pa), 0);
          chk("a_we_expected", 32'(q0.size() > 0), 1);
          if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("a_wr_addr", 32'(a_addr), 32'(e[18:8]));
            chk("a_wr_data", 32'(a_din), 32'(e[7:0]));
          end
          log_a.push_back(int'(a_addr));
          log_d.push_back(a_din);
        end
        if (b_we) begin
          chk("b_we_single", 32'(pb), 0);
          chk("b_we_expected", 32'(q1.size() > 0), 1);
          if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("b_wr_addr", 32'(b_addr), 32'(e[18:8]));
            chk("b_wr_data", 32'(b_din), 32'(e[7:0]));
          end
        end
      end
      pa = a_we;
      pb = b_we;
    end
  endtask

  task automatic check_zero_a(string nm);
    chk({nm, " we"}, 32'(a_we), 0);
    chk({nm, " addr"}, 32'(a_addr), 0);
    chk({nm, " din"}, 32'(a_din), 0);
    chk({nm, " count"}, 32'(a_cnt), 0);
    chk({nm, " done"}, 32'(a_done), 0);
    chk({nm, " perr"}, 32'(a_pe), 0);
    chk({nm, " ferr"}, 32'(a_fe), 0);
    chk({nm, " led"}, 32'(a_led), 0);
  endtask

  task automatic run_tests();
    // reset state
    rstn = 1'b0;
    tick(3);
    check_zero_a("rst_a");
    chk("rst_b led", 32'(b_led), 0);
    chk("rst_b count", 32'(b_cnt), 0);
    rstn = 1'b1;
    tick(2);
    check_state(0, "idle_a");

    // four good bytes fill depth 4, address wraps
    arm(0);
    good(0, 8'h55);
    good(0, 8'hA3);
    good(0, 8'h00);
    good(0, 8'hFF);
    check_state(0, "fill");
    chk("lit nwrites", 32'(log_a.size()), 4);
    chk("lit w0 a", 32'(log_a[0]), 0);
    chk("lit w0 d", 32'(log_d[0]), 32'h55);
    chk("lit w1 a", 32'(log_a[1]), 1);
    chk("lit w1 d", 32'(log_d[1]), 32'hA3);
    chk("lit w2 d", 32'(log_d[2]), 32'h00);
    chk("lit w3 a", 32'(log_a[3]), 3);
    chk("lit w3 d", 32'(log_d[3]), 32'hFF);
    chk("lit count", 32'(a_cnt), 4);
    chk("lit led", 32'(a_led), 32'h03);
    chk("lit addr wrap", 32'(a_addr), 0);
    good(0, 8'h99);
    check_state(0, "done_ignore");
    disarm(0);
    check_state(0, "disarm_done");

    // parity error drops the byte
    arm(0);
    frame(0, 8'h01, 1'b0, 1'b1);
    check_state(0, "bad_par");
    frame(0, 8'h01, 1'b1, 1'b1);
    check_state(0, "par_then_good");
    chk("lit par nwrites", 32'(log_a.size()), 5);
    chk("lit par a", 32'(log_a[4]), 0);
    chk("lit par d", 32'(log_d[4]), 32'h01);
    chk("lit perr", 32'(a_pe), 1);
    disarm(0);

    // framing error drops the byte
    arm(0);
    frame(0, 8'h7E, ^8'h7E, 1'b0);
    check_state(0, "bad_stop");
    good(0, 8'h7E);
    check_state(0, "stop_then_good");
    disarm(0);

    // short low glitch
    arm(0);
    a_rxd = 1'b0;
    tick(4);
    a_rxd = 1'b1;
    tick(3 * CPB_A);
    check_state(0, "glitch");
    good(0, 8'hC6);
    check_state(0, "glitch_then_good");
    disarm(0);

    // reset in the middle of a frame
    arm(0);
    good(0, 8'h11);
    good(0, 8'h22);
    a_rxd = 1'b0;
    tick(CPB_A);
    for (int i = 0; i < 4; i++) begin
      a_rxd = i[0] ? 1'b0 : (i == 0);
      tick(CPB_A);
    end
    a_rxd = 1'b1;
    tick(CPB_A / 2);
    a_en = 1'b0;
    rstn = 1'b0;
    tick(1);
    check_zero_a("midrst");
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      m_st[c]   = 0;
      m_cnt[c]  = 0;
      m_addr[c] = 0;
      m_pe[c]   = 1'b0;
      m_fe[c]   = 1'b0;
    end
    tick(8 * CPB_A);
    check_state(0, "after_rst");
    arm(0);
    good(0, 8'h3C);
    check_state(0, "rearm");
    chk("lit rearm a", 32'(log_a[log_a.size() - 1]), 0);
    chk("lit rearm d", 32'(log_d[log_d.size() - 1]), 32'h3C);
    disarm(0);

    // full-depth fill, 2049th byte ignored
    arm(1);
    for (int i = 0; i < DEP_B + 1; i++) begin
      good(1, 8'((i * 37 + 5) & 255));
    end
    tick(4 * CPB_B);
    check_state(1, "full");
    chk("lit full count", 32'(b_cnt), 2048);
    chk("lit full done", 32'(b_done), 1);
    chk("lit full wrap", 32'(b_addr), 0);
    disarm(1);
    check_state(1, "full_disarm");
    chk("lit disarm done", 32'(b_done), 0);
    chk("lit disarm led", 32'(b_led), 32'hC0);
  endtask

  initial begin
    rstn  = 1'b0;
    a_rxd = 1'b1;
    b_rxd = 1'b1;
    a_en  = 1'b0;
    b_en  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_st[c]   = 0;
      m_cnt[c]  = 0;
      m_addr[c] = 0;
      m_pe[c]   = 1'b0;
      m_fe[c]   = 1'b0;
    end
    fork
      compare_loop();
      run_tests();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
